// File: rtl/efuse_seq_ctrl.sv
// ---------------------------------------------------------------------------
// efuse_seq_ctrl
//   eFuse access sequencer between reg_ctrl/PMU and the eFuse read/write macro
//   drivers. Supports power-up autoload of the full array into a shadow
//   register, manual word read, password-gated word write with optional
//   read-back verify, and a manual blank check. Each macro access has a
//   programmable timeout, and errors are reported in a sticky status field.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   pmu_efuse_start         autoload request pulse (wins over rg_efuse_start)
//   rg_efuse_mode           0=read 1=write 2=blank check 3=reserved
//   rg_efuse_start          manual start pulse
//   rg_efuse_read_sel       manual read word index
//   rg_efuse_write_sel      manual write word index
//   rg_efuse_password       write key
//   rg_efuse_wdata          write data
//   rg_efuse_verify_en      read back the word after a write
//   rg_efuse_timeout        max wait cycles per access, 0 = no timeout
//   rg_efuse_rdata          last manual or verify read data
//   rg_efuse_done           sticky manual-op done
//   rg_efuse_err            sticky {verify_fail, pwd_reject, timeout}
//   rg_efuse_no_blank       array contains a nonzero bit
//   efuse_shadow            autoloaded array image
//   efuse_autoload_done     sticky autoload complete
//   efuse_autoload_vld      one-cycle pulse at autoload completion
//   efuse_busy              sequencer not idle
//   efuse_read_sel/read_start/read_done/read_data      read macro handshake
//   efuse_write_sel/write_start/write_done/write_data  write macro handshake
// ---------------------------------------------------------------------------
module efuse_seq_ctrl #(
    parameter int          TOTAL_BITS = 256,
    parameter int          NR         = 64,
    parameter int          NW         = 64,
    parameter logic [15:0] PASSWORD   = 16'h55AA,
    parameter int          TW         = 12,
    localparam int         NRD        = TOTAL_BITS / NR,
    localparam int         NWD        = TOTAL_BITS / NW,
    localparam int         RSW        = (NRD > 1) ? $clog2(NRD) : 1,
    localparam int         WSW        = (NWD > 1) ? $clog2(NWD) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pmu_efuse_start,
    input  logic [1:0]            rg_efuse_mode,
    input  logic                  rg_efuse_start,
    input  logic [RSW-1:0]        rg_efuse_read_sel,
    input  logic [WSW-1:0]        rg_efuse_write_sel,
    input  logic [15:0]           rg_efuse_password,
    input  logic [NW-1:0]         rg_efuse_wdata,
    input  logic                  rg_efuse_verify_en,
    input  logic [TW-1:0]         rg_efuse_timeout,
    output logic [NR-1:0]         rg_efuse_rdata,
    output logic                  rg_efuse_done,
    output logic [2:0]            rg_efuse_err,
    output logic                  rg_efuse_no_blank,
    output logic [TOTAL_BITS-1:0] efuse_shadow,
    output logic                  efuse_autoload_done,
    output logic                  efuse_autoload_vld,
    output logic                  efuse_busy,
    output logic [RSW-1:0]        efuse_read_sel,
    output logic [WSW-1:0]        efuse_write_sel,
    output logic                  read_start,
    input  logic                  read_done,
    input  logic [NR-1:0]         read_data,
    output logic                  write_start,
    input  logic                  write_done,
    output logic [NW-1:0]         write_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_VF_REQ, S_VF_WAIT, S_FINISH
    } state_t;

    typedef enum logic [1:0] {OP_AUTO, OP_RD, OP_BLANK, OP_WR} op_t;

    localparam bit VF_OK = (NR == NW);

    state_t                  state_reg;
    op_t                     op_reg;
    logic [RSW-1:0]          cnt_reg;
    logic [TW-1:0]           tmo_cnt_reg;
    logic                    nb_acc_reg;
    logic                    vf_en_reg;
    logic [WSW-1:0]          wr_sel_reg;
    logic [NW-1:0]           write_data_reg;
    logic [RSW-1:0]          read_sel_reg;
    logic                    read_start_reg;
    logic                    write_start_reg;
    logic [NR-1:0]           rdata_reg;
    logic                    done_reg;
    logic [2:0]              err_reg;
    logic                    no_blank_reg;
    logic [TOTAL_BITS-1:0]   shadow_reg;
    logic                    autoload_done_reg;
    logic                    autoload_vld_reg;
    logic                    busy_reg;

    // Done edge detectors: one history flop per done line; the rising edge
    // is registered so the FSM consumes it the cycle after the edge. Read
    // data is captured on the edge so a pulse-style macro may drop it later.
    logic          rd_done_d1_reg;
    logic          wr_done_d1_reg;
    logic          rd_take_reg;
    logic          wr_take_reg;
    logic [NR-1:0] rd_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_done_d1_reg <= 1'b0;
            wr_done_d1_reg <= 1'b0;
            rd_take_reg    <= 1'b0;
            wr_take_reg    <= 1'b0;
            rd_data_reg    <= '0;
        end else begin
            rd_done_d1_reg <= read_done;
            wr_done_d1_reg <= write_done;
            rd_take_reg    <= read_done & ~rd_done_d1_reg;
            wr_take_reg    <= write_done & ~wr_done_d1_reg;
            if (read_done && !rd_done_d1_reg) begin
                rd_data_reg <= read_data;
            end
        end
    end

    // Verify only makes sense when read and write words line up one-to-one.
    logic           vf_fail;
    logic [RSW-1:0] wr_sel_as_rd;

    if (VF_OK) begin : g_vf
        assign vf_fail      = (rd_data_reg & write_data_reg) != write_data_reg;
        assign wr_sel_as_rd = wr_sel_reg;
    end else begin : g_no_vf
        assign vf_fail      = 1'b0;
        assign wr_sel_as_rd = '0;
    end

    logic tmo_hit;
    logic last_word;
    assign tmo_hit   = (rg_efuse_timeout != '0) && (tmo_cnt_reg == rg_efuse_timeout);
    assign last_word = (cnt_reg == RSW'(NRD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= S_IDLE;
            op_reg            <= OP_AUTO;
            cnt_reg           <= '0;
            tmo_cnt_reg       <= '0;
            nb_acc_reg        <= 1'b0;
            vf_en_reg         <= 1'b0;
            wr_sel_reg        <= '0;
            write_data_reg    <= '0;
            read_sel_reg      <= '0;
            read_start_reg    <= 1'b0;
            write_start_reg   <= 1'b0;
            rdata_reg         <= '0;
            done_reg          <= 1'b0;
            err_reg           <= 3'b000;
            no_blank_reg      <= 1'b0;
            shadow_reg        <= '0;
            autoload_done_reg <= 1'b0;
            autoload_vld_reg  <= 1'b0;
            busy_reg          <= 1'b0;
        end else begin
            read_start_reg   <= 1'b0;
            write_start_reg  <= 1'b0;
            autoload_vld_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (pmu_efuse_start) begin
                        op_reg       <= OP_AUTO;
                        cnt_reg      <= '0;
                        read_sel_reg <= '0;
                        nb_acc_reg   <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= S_RD_REQ;
                    end else if (rg_efuse_start) begin
                        case (rg_efuse_mode)
                            2'd0: begin
                                op_reg       <= OP_RD;
                                read_sel_reg <= rg_efuse_read_sel;
                                done_reg     <= 1'b0;
                                err_reg      <= 3'b000;
                                busy_reg     <= 1'b1;
                                state_reg    <= S_RD_REQ;
                            end
                            2'd1: begin
                                if (rg_efuse_password == PASSWORD) begin
                                    op_reg         <= OP_WR;
                                    write_data_reg <= rg_efuse_wdata;
                                    wr_sel_reg     <= rg_efuse_write_sel;
                                    vf_en_reg      <= rg_efuse_verify_en;
                                    done_reg       <= 1'b0;
                                    err_reg        <= 3'b000;
                                    busy_reg       <= 1'b1;
                                    state_reg      <= S_WR_REQ;
                                end else begin
                                    // Rejected writes never leave IDLE.
                                    err_reg[1] <= 1'b1;
                                    done_reg   <= 1'b1;
                                end
                            end
                            2'd2: begin
                                op_reg       <= OP_BLANK;
                                cnt_reg      <= '0;
                                read_sel_reg <= '0;
                                nb_acc_reg   <= 1'b0;
                                done_reg     <= 1'b0;
                                err_reg      <= 3'b000;
                                busy_reg     <= 1'b1;
                                state_reg    <= S_RD_REQ;
                            end
                            default: ;
                        endcase
                    end
                end

                S_RD_REQ: begin
                    read_start_reg <= 1'b1;
                    tmo_cnt_reg    <= '0;
                    state_reg      <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    if (rd_take_reg) begin
                        case (op_reg)
                            OP_AUTO: begin
                                shadow_reg[int'(cnt_reg)*NR +: NR] <= rd_data_reg;
                                nb_acc_reg <= nb_acc_reg | (|rd_data_reg);
                            end
                            OP_BLANK: nb_acc_reg <= nb_acc_reg | (|rd_data_reg);
                            default:  rdata_reg  <= rd_data_reg;
                        endcase
                        if ((op_reg == OP_AUTO || op_reg == OP_BLANK) && !last_word) begin
                            cnt_reg      <= cnt_reg + 1'b1;
                            read_sel_reg <= cnt_reg + 1'b1;
                            state_reg    <= S_RD_REQ;
                        end else begin
                            state_reg <= S_FINISH;
                        end
                    end else if (tmo_hit) begin
                        // Remaining autoload words are abandoned here.
                        err_reg[0] <= 1'b1;
                        state_reg  <= S_FINISH;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end

                S_WR_REQ: begin
                    write_start_reg <= 1'b1;
                    tmo_cnt_reg     <= '0;
                    state_reg       <= S_WR_WAIT;
                end

                S_WR_WAIT: begin
                    if (wr_take_reg) begin
                        state_reg <= (vf_en_reg && VF_OK) ? S_VF_REQ : S_FINISH;
                    end else if (tmo_hit) begin
                        err_reg[0] <= 1'b1;
                        state_reg  <= S_FINISH;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end

                S_VF_REQ: begin
                    read_start_reg <= 1'b1;
                    read_sel_reg   <= wr_sel_as_rd;
                    tmo_cnt_reg    <= '0;
                    state_reg      <= S_VF_WAIT;
                end

                S_VF_WAIT: begin
                    if (rd_take_reg) begin
                        rdata_reg <= rd_data_reg;
                        // A written 1 that reads back 0 is an unblown fuse.
                        if (vf_fail) begin
                            err_reg[2] <= 1'b1;
                        end
                        state_reg <= S_FINISH;
                    end else if (tmo_hit) begin
                        err_reg[0] <= 1'b1;
                        state_reg  <= S_FINISH;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end

                S_FINISH: begin
                    case (op_reg)
                        OP_AUTO: begin
                            autoload_done_reg <= 1'b1;
                            autoload_vld_reg  <= 1'b1;
                            no_blank_reg      <= nb_acc_reg;
                        end
                        OP_BLANK: begin
                            no_blank_reg <= nb_acc_reg;
                            done_reg     <= 1'b1;
                        end
                        default: done_reg <= 1'b1;
                    endcase
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign rg_efuse_rdata      = rdata_reg;
    assign rg_efuse_done       = done_reg;
    assign rg_efuse_err        = err_reg;
    assign rg_efuse_no_blank   = no_blank_reg;
    assign efuse_shadow        = shadow_reg;
    assign efuse_autoload_done = autoload_done_reg;
    assign efuse_autoload_vld  = autoload_vld_reg;
    assign efuse_busy          = busy_reg;
    assign efuse_read_sel      = read_sel_reg;
    assign efuse_write_sel     = wr_sel_reg;
    assign read_start          = read_start_reg;
    assign write_start         = write_start_reg;
    assign write_data          = write_data_reg;

endmodule
